chandrakanth_nand: RTL and testbench

// - Tiny-Tapeout user block: a 4-bit NAND-only logic/arithmetic unit.
// - Every function is built solely from 2-input NAND primitives.
// - Two 4-bit operands and a 3-bit opcode come in; a registered 4-bit result plus status flags go out.
// - Top-level user project.
// - Pin map follows the standard tt_um interface.

---
 rtl/chandrakanth_nand_pkg.sv | 21 ++
 rtl/chandrakanth_nand2.sv | 11 +
 rtl/chandrakanth_nand.sv | 152 +++++++++++++++
 tb/tb_chandrakanth_nand.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/chandrakanth_nand_pkg.sv
// rtl/chandrakanth_nand_pkg.sv - opcode encodings and uo_out field positions
package chandrakanth_nand_pkg;

  // Opcode encodings; the value is also the slot index in the result mux
  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_ADD  = 3'd7;

  // uo_out field positions
  localparam int RES_LSB   = 0;
  localparam int ZERO_BIT  = 4;
  localparam int CARRY_BIT = 5;
  localparam int PAR_BIT   = 6;
  localparam int VALID_BIT = 7;

endpackage

// File: rtl/chandrakanth_nand2.sv
// rtl/chandrakanth_nand2.sv - 2-input NAND primitive
// Ports: a, b inputs; y = ~(a & b)
module chandrakanth_nand2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/chandrakanth_nand.sv
// rtl/chandrakanth_nand.sv - 4-bit NAND-only logic/arithmetic unit, tt_um pinout
// Ports: clk, rst_n (async active-low), ena (hold when 0),
//        ui_in  [3:0]=A [7:4]=B, uio_in [2:0]=opcode,
//        uo_out [3:0]=result [4]=zero [5]=carry [6]=parity [7]=valid,
//        uio_out / uio_oe tied to 0.
module chandrakanth_nand
  import chandrakanth_nand_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  logic [3:0] a, b;
  logic [2:0] op, op_n;
  logic       unused_uio;

  assign a          = ui_in[3:0];
  assign b          = ui_in[7:4];
  assign op         = uio_in[2:0];
  assign unused_uio = &uio_in[7:3];
  assign uio_out    = 8'h00;
  assign uio_oe     = 8'h00;

  // Per-bit function network. The adder reuses the NAND term and the XOR
  // result as the first half-adder stage, so each full adder costs 5 extra gates.
  logic [3:0] f_nand, f_and, f_or, f_nor, f_xor, f_xnor, f_nota, f_add;
  logic [3:0] b_n, x_a, x_b, s_t, s_a, s_c;
  logic [4:0] cy;

  assign cy[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_fn
    chandrakanth_nand2 u_nand (.a(a[i]),      .b(b[i]),      .y(f_nand[i]));
    chandrakanth_nand2 u_and  (.a(f_nand[i]), .b(f_nand[i]), .y(f_and[i]));
    chandrakanth_nand2 u_na   (.a(a[i]),      .b(a[i]),      .y(f_nota[i]));
    chandrakanth_nand2 u_nb   (.a(b[i]),      .b(b[i]),      .y(b_n[i]));
    chandrakanth_nand2 u_or   (.a(f_nota[i]), .b(b_n[i]),    .y(f_or[i]));
    chandrakanth_nand2 u_nor  (.a(f_or[i]),   .b(f_or[i]),   .y(f_nor[i]));
    chandrakanth_nand2 u_xa   (.a(a[i]),      .b(f_nand[i]), .y(x_a[i]));
    chandrakanth_nand2 u_xb   (.a(b[i]),      .b(f_nand[i]), .y(x_b[i]));
    chandrakanth_nand2 u_xor  (.a(x_a[i]),    .b(x_b[i]),    .y(f_xor[i]));
    chandrakanth_nand2 u_xnor (.a(f_xor[i]),  .b(f_xor[i]),  .y(f_xnor[i]));
    chandrakanth_nand2 u_st   (.a(f_xor[i]),  .b(cy[i]),     .y(s_t[i]));
    chandrakanth_nand2 u_sa   (.a(f_xor[i]),  .b(s_t[i]),    .y(s_a[i]));
    chandrakanth_nand2 u_sc   (.a(cy[i]),     .b(s_t[i]),    .y(s_c[i]));
    chandrakanth_nand2 u_sum  (.a(s_a[i]),    .b(s_c[i]),    .y(f_add[i]));
    chandrakanth_nand2 u_cout (.a(s_t[i]),    .b(f_nand[i]), .y(cy[i+1]));
  end

  // All eight results, slot n holds opcode n
  logic [31:0] fn;
  always_comb begin
    fn = '0;
    fn[int'(OP_NAND)*4 +: 4] = f_nand;
    fn[int'(OP_AND)*4  +: 4] = f_and;
    fn[int'(OP_OR)*4   +: 4] = f_or;
    fn[int'(OP_NOR)*4  +: 4] = f_nor;
    fn[int'(OP_XOR)*4  +: 4] = f_xor;
    fn[int'(OP_XNOR)*4 +: 4] = f_xnor;
    fn[int'(OP_NOTA)*4 +: 4] = f_nota;
    fn[int'(OP_ADD)*4  +: 4] = f_add;
  end

  for (genvar j = 0; j < 3; j++) begin : g_opn
    chandrakanth_nand2 u_inv (.a(op[j]), .b(op[j]), .y(op_n[j]));
  end

  // 8:1 mux as a 3-level tree of NAND 2:1 muxes: y = ~(~(d1&s) & ~(d0&~s))
  logic [15:0] l1;
  logic [7:0]  l2;
  logic [3:0]  res;

  for (genvar k = 0; k < 16; k++) begin : g_l1
    logic p, q;
    chandrakanth_nand2 u_p (.a(fn[(2*(k/4)+1)*4 + k%4]), .b(op[0]),   .y(p));
    chandrakanth_nand2 u_q (.a(fn[(2*(k/4))*4 + k%4]),   .b(op_n[0]), .y(q));
    chandrakanth_nand2 u_y (.a(p), .b(q), .y(l1[k]));
  end

  for (genvar k = 0; k < 8; k++) begin : g_l2
    logic p, q;
    chandrakanth_nand2 u_p (.a(l1[(2*(k/4)+1)*4 + k%4]), .b(op[1]),   .y(p));
    chandrakanth_nand2 u_q (.a(l1[(2*(k/4))*4 + k%4]),   .b(op_n[1]), .y(q));
    chandrakanth_nand2 u_y (.a(p), .b(q), .y(l2[k]));
  end

  for (genvar k = 0; k < 4; k++) begin : g_l3
    logic p, q;
    chandrakanth_nand2 u_p (.a(l2[4+k]), .b(op[2]),   .y(p));
    chandrakanth_nand2 u_q (.a(l2[k]),   .b(op_n[2]), .y(q));
    chandrakanth_nand2 u_y (.a(p), .b(q), .y(res[k]));
  end

  // Parity: three XORs, tree (r0^r1) ^ (r2^r3); stage 2 consumes stages 0/1
  logic [2:0] px_a, px_b, px_y, px_t, px_u, px_v;
  assign px_a = {px_y[0], res[2], res[0]};
  assign px_b = {px_y[1], res[3], res[1]};

  for (genvar k = 0; k < 3; k++) begin : g_par
    chandrakanth_nand2 u_t (.a(px_a[k]), .b(px_b[k]), .y(px_t[k]));
    chandrakanth_nand2 u_u (.a(px_a[k]), .b(px_t[k]), .y(px_u[k]));
    chandrakanth_nand2 u_v (.a(px_b[k]), .b(px_t[k]), .y(px_v[k]));
    chandrakanth_nand2 u_y (.a(px_u[k]), .b(px_v[k]), .y(px_y[k]));
  end

  // Zero: AND of the four inverted result bits
  logic [3:0] res_n;
  logic       z_a01, z_a23, z_i01, z_i23, z_n, zero;

  for (genvar k = 0; k < 4; k++) begin : g_zinv
    chandrakanth_nand2 u_inv (.a(res[k]), .b(res[k]), .y(res_n[k]));
  end
  chandrakanth_nand2 u_z01 (.a(res_n[0]), .b(res_n[1]), .y(z_a01));
  chandrakanth_nand2 u_z23 (.a(res_n[2]), .b(res_n[3]), .y(z_a23));
  chandrakanth_nand2 u_zi0 (.a(z_a01),    .b(z_a01),    .y(z_i01));
  chandrakanth_nand2 u_zi1 (.a(z_a23),    .b(z_a23),    .y(z_i23));
  chandrakanth_nand2 u_zn  (.a(z_i01),    .b(z_i23),    .y(z_n));
  chandrakanth_nand2 u_z   (.a(z_n),      .b(z_n),      .y(zero));

  // Carry: adder carry-out gated by op == ADD (all opcode bits high)
  logic c_n01, c_i01, c_s7n, c_s7, c_n, carry;
  chandrakanth_nand2 u_c01 (.a(op[0]), .b(op[1]),  .y(c_n01));
  chandrakanth_nand2 u_ci  (.a(c_n01), .b(c_n01),  .y(c_i01));
  chandrakanth_nand2 u_s7n (.a(c_i01), .b(op[2]),  .y(c_s7n));
  chandrakanth_nand2 u_s7  (.a(c_s7n), .b(c_s7n),  .y(c_s7));
  chandrakanth_nand2 u_cn  (.a(c_s7),  .b(cy[4]),  .y(c_n));
  chandrakanth_nand2 u_c   (.a(c_n),   .b(c_n),    .y(carry));

  logic [7:0] out_d, out_q;
  always_comb begin
    out_d                 = '0;
    out_d[RES_LSB +: 4]   = res;
    out_d[ZERO_BIT]       = zero;
    out_d[CARRY_BIT]      = carry;
    out_d[PAR_BIT]        = px_y[2];
    out_d[VALID_BIT]      = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_q <= '0;
    else if (ena) out_q <= out_d;
  end

  assign uo_out = out_q;

endmodule

// File: tb/tb_chandrakanth_nand.sv
// tb/tb_chandrakanth_nand.sv - scoreboard bench for chandrakanth_nand
module tb_chandrakanth_nand;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_q;

  chandrakanth_nand dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Reference: arithmetic on integers, flags derived from the result value
  function automatic logic [7:0] ref_out(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    int r;
    int c;
    logic [3:0] res;
    c = 0;
    case (op)
      3'd0: r = 15 - int'(a & b);
      3'd1: r = int'(a & b);
      3'd2: r = int'(a | b);
      3'd3: r = 15 - int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - int'(a ^ b);
      3'd6: r = 15 - int'(a);
      default: begin
        r = int'(a) + int'(b);
        c = r / 16;
        r = r % 16;
      end
    endcase
    res = r[3:0];
    return {1'b1, ($countones(res) % 2) == 1, c == 1, res == 4'h0, res};
  endfunction

  // One clock of stimulus; the expected uo_out after that edge goes to the queue
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic en, input logic use_lit, input logic [7:0] lit);
    @(negedge clk);
    ui_in  = {b, a};
    uio_in = {5'($urandom), op};
    ena    = en;
    if (en) model_q = ref_out(a, b, op);
    exp_q.push_back(use_lit ? lit : model_q);
  endtask

  // Monitor: compare one expectation shortly after every active edge
  always @(posedge clk) begin
    logic [7:0] e;
    #2;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("uo_out", uo_out, e);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b0;
    ui_in   = 8'h00;
    uio_in  = 8'h00;
    model_q = 8'h00;
    #3;
    check("reset_uo_out",  uo_out,  8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe",  uio_oe,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with fixed expected bytes
    issue(4'hC, 4'hA, 3'd0, 1'b1, 1'b1, 8'hC7);
    issue(4'hC, 4'hA, 3'd1, 1'b1, 1'b1, 8'hC8);
    issue(4'hC, 4'hA, 3'd2, 1'b1, 1'b1, 8'hCE);
    issue(4'hF, 4'h1, 3'd7, 1'b1, 1'b1, 8'hB0);
    issue(4'h3, 4'h4, 3'd7, 1'b1, 1'b1, 8'hC7);
    issue(4'h5, 4'h5, 3'd4, 1'b1, 1'b1, 8'h90);
    issue(4'h5, 4'(($urandom)), 3'd6, 1'b1, 1'b1, 8'h8A);

    // Hold with ena low while inputs churn
    issue(4'h3, 4'h4, 3'd7, 1'b1, 1'b1, 8'hC7);
    for (int i = 0; i < 5; i++)
      issue(4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b1, 8'hC7);

    // Asynchronous clear between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_clear_uo_out",  uo_out,  8'h00);
    check("async_clear_uio_out", uio_out, 8'h00);
    check("async_clear_uio_oe",  uio_oe,  8'h00);
    model_q = 8'h00;
    exp_q.delete();
    #1;
    rst_n = 1'b1;

    // valid stays low until the first enabled edge after reset
    issue(4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 1'b1, 8'h00);
    issue(4'h9, 4'h8, 3'd7, 1'b1, 1'b1, 8'hE1);

    // Exhaustive sweep against the reference model
    for (int op = 0; op < 8; op++)
      for (int ab = 0; ab < 256; ab++)
        issue(4'(ab), 4'(ab >> 4), 3'(op), 1'b1, 1'b0, 8'h00);

    // Random mix of enabled and held cycles
    for (int i = 0; i < 400; i++)
      issue(4'($urandom), 4'($urandom), 3'($urandom), $urandom_range(0, 3) != 0, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
